// File: rtl/pixel_plot_arbiter.sv
//------------------------------------------------------------------------------
// pixel_plot_arbiter
//
// Merges three pixel streams (gold sprite, stone sprite, background) into one
// VGA adapter write port. Requests are granted with fixed priority
// gold > stone > bg. Each accepted pixel is either discarded (sprite colour
// equal to KEY, or coordinate off the 320x240 screen) or queued in a 4-entry
// FIFO. One queued pixel is written to the adapter per cycle unless the frame
// buffer stalls.
//
// Parameters
//   KEY          sprite transparency colour (gold/stone only)
//
// Ports
//   clk          system clock, rising edge
//   resetn       synchronous, active-low reset
//   gold_*       gold pixel stream   (valid/ready, x[8:0], y[7:0], color[11:0])
//   stone_*      stone pixel stream  (valid/ready, x[8:0], y[7:0], color[11:0])
//   bg_*         background stream   (valid/ready, x[8:0], y[8:0], color[11:0])
//   vga_stall    frame buffer cannot take a pixel this cycle
//   clear_count  synchronous clear of plot_count
//   vga_x/y      registered write coordinate
//   vga_colour   registered write colour
//   vga_plot     write strobe, high for one cycle per pixel
//   plot_count   pixels plotted since reset/clear, saturating
//   busy         FIFO holds data or any source is requesting
//------------------------------------------------------------------------------
`timescale 1ns/1ps

module pixel_plot_arbiter #(
    parameter logic [11:0] KEY = 12'hF0F
) (
    input  logic        clk,
    input  logic        resetn,

    input  logic        gold_valid,
    output logic        gold_ready,
    input  logic [8:0]  gold_x,
    input  logic [7:0]  gold_y,
    input  logic [11:0] gold_color,

    input  logic        stone_valid,
    output logic        stone_ready,
    input  logic [8:0]  stone_x,
    input  logic [7:0]  stone_y,
    input  logic [11:0] stone_color,

    input  logic        bg_valid,
    output logic        bg_ready,
    input  logic [8:0]  bg_x,
    input  logic [8:0]  bg_y,
    input  logic [11:0] bg_color,

    input  logic        vga_stall,
    input  logic        clear_count,

    output logic [8:0]  vga_x,
    output logic [7:0]  vga_y,
    output logic [11:0] vga_colour,
    output logic        vga_plot,
    output logic [16:0] plot_count,
    output logic        busy
);

    localparam int          DEPTH     = 4;
    localparam logic [2:0]  FULL_CNT  = 3'd4;
    localparam logic [8:0]  X_LIMIT   = 9'd320;
    localparam logic [8:0]  Y_LIMIT   = 9'd240;
    localparam logic [16:0] COUNT_MAX = 17'h1FFFF;

    typedef enum logic [1:0] {
        SRC_NONE,
        SRC_GOLD,
        SRC_STONE,
        SRC_BG
    } src_e;

    typedef struct packed {
        logic [8:0]  x;
        logic [7:0]  y;
        logic [11:0] colour;
    } pixel_t;

    // FIFO storage and control
    pixel_t      mem_q [DEPTH];
    logic [1:0]  wr_ptr_q, wr_ptr_d;
    logic [1:0]  rd_ptr_q, rd_ptr_d;
    logic [2:0]  count_q,  count_d;

    // Output registers
    pixel_t      vga_pix_q, vga_pix_d;
    logic        vga_plot_q, vga_plot_d;
    logic [16:0] plot_count_q, plot_count_d;

    // Grant / datapath signals
    src_e        src_sel;
    pixel_t      in_pix;
    logic [8:0]  in_y_wide;
    logic        in_keyed;
    logic        in_off_screen;
    logic        push;
    logic        pop;

    //--------------------------------------------------------------------------
    // Arbitration. The full check uses the registered count only, so a pop on
    // the same edge never opens a slot for a push while full. Reset blocks all
    // grants.
    //--------------------------------------------------------------------------
    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can
        // leave it unassigned and infer a latch.
        src_sel = SRC_NONE;
        if (resetn && (count_q < FULL_CNT)) begin
            if (gold_valid) begin
                src_sel = SRC_GOLD;
            end else if (stone_valid) begin
                src_sel = SRC_STONE;
            end else if (bg_valid) begin
                src_sel = SRC_BG;
            end
        end
    end

    assign gold_ready  = (src_sel == SRC_GOLD);
    assign stone_ready = (src_sel == SRC_STONE);
    assign bg_ready    = (src_sel == SRC_BG);

    //--------------------------------------------------------------------------
    // Selected pixel and drop decision. The bg stream carries a 9-bit y so
    // that off-screen rows up to 511 can be rejected; only the low byte is
    // stored. Background pixels are never colour-keyed.
    //--------------------------------------------------------------------------
    always_comb begin
        in_pix    = '0;
        in_y_wide = '0;
        in_keyed  = 1'b0;
        unique case (src_sel)
            SRC_GOLD: begin
                in_pix    = '{x: gold_x, y: gold_y, colour: gold_color};
                in_y_wide = {1'b0, gold_y};
                in_keyed  = (gold_color == KEY);
            end
            SRC_STONE: begin
                in_pix    = '{x: stone_x, y: stone_y, colour: stone_color};
                in_y_wide = {1'b0, stone_y};
                in_keyed  = (stone_color == KEY);
            end
            SRC_BG: begin
                in_pix    = '{x: bg_x, y: bg_y[7:0], colour: bg_color};
                in_y_wide = bg_y;
            end
            default: begin
                in_pix = '0;
            end
        endcase
    end

    assign in_off_screen = (in_pix.x >= X_LIMIT) || (in_y_wide >= Y_LIMIT);

    // Dropped pixels are still handshaked (consumed) but never stored.
    assign push = (src_sel != SRC_NONE) && !in_keyed && !in_off_screen;
    assign pop  = (count_q != 3'd0) && !vga_stall;

    //--------------------------------------------------------------------------
    // Next-state logic for FIFO control, output registers and plot counter.
    //--------------------------------------------------------------------------
    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        vga_pix_d    = vga_pix_q;
        vga_plot_d   = 1'b0;
        plot_count_d = plot_count_q;

        // Pointers are 2 bits wide, so they wrap modulo 4 naturally.
        if (push) begin
            wr_ptr_d = wr_ptr_q + 2'd1;
        end
        if (pop) begin
            rd_ptr_d   = rd_ptr_q + 2'd1;
            vga_pix_d  = mem_q[rd_ptr_q];
            vga_plot_d = 1'b1;
        end

        // Simultaneous push and pop leaves the occupancy unchanged.
        count_d = count_q + {2'b00, push} - {2'b00, pop};

        // Clear wins over a simultaneous increment.
        if (clear_count) begin
            plot_count_d = '0;
        end else if (pop && (plot_count_q != COUNT_MAX)) begin
            plot_count_d = plot_count_q + 17'd1;
        end
    end

    //--------------------------------------------------------------------------
    // Control and output registers, synchronous active-low reset. Reset takes
    // precedence over a pending pop, so nothing is plotted on the reset edge
    // and queued entries are abandoned.
    //--------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: registers use non-blocking assignments so every flop samples
        // the pre-edge value of its inputs, independent of statement order.
        if (!resetn) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            vga_pix_q    <= '0;
            vga_plot_q   <= 1'b0;
            plot_count_q <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            vga_pix_q    <= vga_pix_d;
            vga_plot_q   <= vga_plot_d;
            plot_count_q <= plot_count_d;
        end
    end

    // NOTE: the storage array has no reset; count and pointers alone define
    // which entries are valid, so resetting the data would only cost logic.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= in_pix;
        end
    end

    //--------------------------------------------------------------------------
    // Outputs
    //--------------------------------------------------------------------------
    assign vga_x      = vga_pix_q.x;
    assign vga_y      = vga_pix_q.y;
    assign vga_colour = vga_pix_q.colour;
    assign vga_plot   = vga_plot_q;
    assign plot_count = plot_count_q;

    assign busy = (count_q != 3'd0) || gold_valid || stone_valid || bg_valid;

endmodule

// File: tb/tb_pixel_plot_arbiter.sv
//------------------------------------------------------------------------------
// tb_pixel_plot_arbiter
//
// Directed stimulus with hand-computed expectations. Stimulus pushes every
// pixel that should reach the screen into exp_q; an independent monitor pops
// and compares whenever vga_plot is high.
//------------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_pixel_plot_arbiter;

    typedef struct packed {
        logic [8:0]  x;
        logic [7:0]  y;
        logic [11:0] c;
    } pix_t;

    logic        clk = 1'b0;
    logic        resetn;
    logic        gold_valid, gold_ready;
    logic [8:0]  gold_x;
    logic [7:0]  gold_y;
    logic [11:0] gold_color;
    logic        stone_valid, stone_ready;
    logic [8:0]  stone_x;
    logic [7:0]  stone_y;
    logic [11:0] stone_color;
    logic        bg_valid, bg_ready;
    logic [8:0]  bg_x;
    logic [8:0]  bg_y;
    logic [11:0] bg_color;
    logic        vga_stall;
    logic        clear_count;
    logic [8:0]  vga_x;
    logic [7:0]  vga_y;
    logic [11:0] vga_colour;
    logic        vga_plot;
    logic [16:0] plot_count;
    logic        busy;

    pix_t exp_q[$];
    pix_t mon_exp;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    pixel_plot_arbiter #(.KEY(12'hF0F)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .gold_valid  (gold_valid),
        .gold_ready  (gold_ready),
        .gold_x      (gold_x),
        .gold_y      (gold_y),
        .gold_color  (gold_color),
        .stone_valid (stone_valid),
        .stone_ready (stone_ready),
        .stone_x     (stone_x),
        .stone_y     (stone_y),
        .stone_color (stone_color),
        .bg_valid    (bg_valid),
        .bg_ready    (bg_ready),
        .bg_x        (bg_x),
        .bg_y        (bg_y),
        .bg_color    (bg_color),
        .vga_stall   (vga_stall),
        .clear_count (clear_count),
        .vga_x       (vga_x),
        .vga_y       (vga_y),
        .vga_colour  (vga_colour),
        .vga_plot    (vga_plot),
        .plot_count  (plot_count),
        .busy        (busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic pix_t mk(input int x, input int y, input int c);
        pix_t p;
        p.x = 9'(x);
        p.y = 8'(y);
        p.c = 12'(c);
        return p;
    endfunction

    // Monitor: every plot must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (vga_plot === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_plot: got %0h expected none",
                         {vga_x, vga_y, vga_colour});
            end else begin
                mon_exp = exp_q.pop_front();
                check("plot_pixel", 32'({vga_x, vga_y, vga_colour}), 32'(mon_exp));
            end
        end
    end

    // Global time limit so the bench can never hang.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic idle_inputs();
        gold_valid  = 1'b0; gold_x  = '0; gold_y  = '0; gold_color  = '0;
        stone_valid = 1'b0; stone_x = '0; stone_y = '0; stone_color = '0;
        bg_valid    = 1'b0; bg_x    = '0; bg_y    = '0; bg_color    = '0;
    endtask

    task automatic drive_bg(input int x, input int y, input int c);
        bg_valid = 1'b1;
        bg_x     = 9'(x);
        bg_y     = 9'(y);
        bg_color = 12'(c);
    endtask

    // Bounded wait for the scoreboard to empty and the block to go idle.
    task automatic wait_drain(input string name);
        bit done = 1'b0;
        for (int i = 0; i < 30 && !done; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !busy && !vga_plot) done = 1'b1;
        end
        check({"drain_", name}, 32'(done), 32'd1);
    endtask

    // Offer one on-screen bg pixel, optionally clearing the counter on the
    // edge that plots it. Returns at the negedge where vga_plot is high.
    task automatic plot_one(input int x, input int y, input int c, input bit clr);
        @(negedge clk);
        drive_bg(x, y, c);
        #1 check("plot_one_ready", 32'(bg_ready), 32'd1);
        exp_q.push_back(mk(x, y, c));
        @(negedge clk);
        bg_valid    = 1'b0;
        clear_count = clr;
        @(negedge clk);
        clear_count = 1'b0;
        check("plot_one_strobe", 32'(vga_plot), 32'd1);
    endtask

    initial begin
        bit found;

        resetn      = 1'b0;
        vga_stall   = 1'b0;
        clear_count = 1'b0;
        idle_inputs();

        // ---------------- reset state, readies gated by reset ----------------
        @(negedge clk);
        gold_valid = 1'b1;
        drive_bg(1, 1, 1);
        #1;
        check("rst_gold_ready", 32'(gold_ready), 32'd0);
        check("rst_bg_ready", 32'(bg_ready), 32'd0);
        @(negedge clk);
        check("rst_vga_plot", 32'(vga_plot), 32'd0);
        check("rst_plot_count", 32'(plot_count), 32'd0);
        check("rst_vga_xyc", 32'({vga_x, vga_y, vga_colour}), 32'd0);
        idle_inputs();
        #1 check("rst_busy", 32'(busy), 32'd0);
        resetn = 1'b1;

        // ---------------- single bg pixel, latency ----------------
        @(negedge clk);
        drive_bg(10, 20, 12'h123);
        #1 check("single_bg_ready", 32'(bg_ready), 32'd1);
        exp_q.push_back(mk(10, 20, 12'h123));
        @(negedge clk);
        bg_valid = 1'b0;
        check("single_no_bypass", 32'(vga_plot), 32'd0);
        @(negedge clk);
        check("single_plot", 32'(vga_plot), 32'd1);
        check("single_count", 32'(plot_count), 32'd1);
        wait_drain("single");

        // ---------------- priority gold > stone > bg ----------------
        @(negedge clk);
        gold_valid  = 1'b1; gold_x  = 9'd1; gold_y  = 8'd2; gold_color  = 12'hAAA;
        stone_valid = 1'b1; stone_x = 9'd3; stone_y = 8'd4; stone_color = 12'hBBB;
        drive_bg(5, 6, 12'hCCC);
        #1;
        check("prio1_gold", 32'(gold_ready), 32'd1);
        check("prio1_stone", 32'(stone_ready), 32'd0);
        check("prio1_bg", 32'(bg_ready), 32'd0);
        exp_q.push_back(mk(1, 2, 12'hAAA));
        @(negedge clk);
        gold_valid = 1'b0;
        #1;
        check("prio2_gold", 32'(gold_ready), 32'd0);
        check("prio2_stone", 32'(stone_ready), 32'd1);
        check("prio2_bg", 32'(bg_ready), 32'd0);
        exp_q.push_back(mk(3, 4, 12'hBBB));
        @(negedge clk);
        stone_valid = 1'b0;
        check("prio_plot1", 32'(vga_plot), 32'd1);
        #1 check("prio3_bg", 32'(bg_ready), 32'd1);
        exp_q.push_back(mk(5, 6, 12'hCCC));
        @(negedge clk);
        bg_valid = 1'b0;
        check("prio_plot2", 32'(vga_plot), 32'd1);
        @(negedge clk);
        check("prio_plot3", 32'(vga_plot), 32'd1);
        check("prio_count", 32'(plot_count), 32'd4);
        wait_drain("prio");

        // ---------------- drop rules and bounds ----------------
        @(negedge clk);
        gold_valid = 1'b1; gold_x = 9'd5; gold_y = 8'd5; gold_color = 12'hF0F;
        #1 check("key_gold_ready", 32'(gold_ready), 32'd1);
        @(negedge clk);
        gold_valid  = 1'b0;
        stone_valid = 1'b1; stone_x = 9'd320; stone_y = 8'd0; stone_color = 12'h0AA;
        #1 check("oob_stone_ready", 32'(stone_ready), 32'd1);
        @(negedge clk);
        stone_valid = 1'b0;
        check("key_gold_no_plot", 32'(vga_plot), 32'd0);
        drive_bg(0, 240, 12'h0BB);
        #1 check("oob_bg_ready", 32'(bg_ready), 32'd1);
        @(negedge clk);
        check("oob_stone_no_plot", 32'(vga_plot), 32'd0);
        drive_bg(319, 239, 12'hF0F);
        #1 check("edge_bg_ready", 32'(bg_ready), 32'd1);
        exp_q.push_back(mk(319, 239, 12'hF0F));
        @(negedge clk);
        bg_valid = 1'b0;
        check("oob_bg_no_plot", 32'(vga_plot), 32'd0);
        check("drop_count", 32'(plot_count), 32'd4);
        @(negedge clk);
        check("edge_bg_plot", 32'(vga_plot), 32'd1);
        check("edge_count", 32'(plot_count), 32'd5);
        wait_drain("drop");

        // ---------------- stall, full FIFO, back-pressure ----------------
        @(negedge clk);
        vga_stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_no_plot", 32'(vga_plot), 32'd0);
            drive_bg(100 + i, 50 + i, 12'h300 + i);
            #1;
            if (i < 4) begin
                check("stall_accept", 32'(bg_ready), 32'd1);
                exp_q.push_back(mk(100 + i, 50 + i, 12'h300 + i));
            end else begin
                check("full_ready", 32'(bg_ready), 32'd0);
            end
        end
        @(negedge clk);
        check("full_hold_ready", 32'(bg_ready), 32'd0);
        check("full_busy", 32'(busy), 32'd1);
        check("full_no_plot", 32'(vga_plot), 32'd0);
        vga_stall = 1'b0;
        #1 check("full_pop_edge_ready", 32'(bg_ready), 32'd0);
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            @(negedge clk);
            #1;
            if (bg_ready) begin
                found = 1'b1;
                exp_q.push_back(mk(104, 54, 12'h304));
            end
        end
        check("fifth_accepted", 32'(found), 32'd1);
        @(negedge clk);
        bg_valid = 1'b0;
        wait_drain("stall");
        check("stall_count", 32'(plot_count), 32'd10);

        // ---------------- reset mid-operation ----------------
        @(negedge clk);
        vga_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            drive_bg(30 + i, 40 + i, 12'h700 + i);
            #1 check("rst_mid_accept", 32'(bg_ready), 32'd1);
        end
        @(negedge clk);
        bg_valid  = 1'b0;
        vga_stall = 1'b0;
        resetn    = 1'b0;
        @(negedge clk);
        check("rst_mid_plot", 32'(vga_plot), 32'd0);
        check("rst_mid_count", 32'(plot_count), 32'd0);
        check("rst_mid_busy", 32'(busy), 32'd0);
        resetn = 1'b1;
        repeat (6) @(negedge clk);
        check("rst_mid_idle", 32'(busy), 32'd0);

        // ---------------- counter saturation and clear ----------------
        @(negedge clk);
        force dut.plot_count_q = 17'h1FFFE;
        #1 release dut.plot_count_q;
        #1 check("preset_count", 32'(plot_count), 32'h1FFFE);
        plot_one(200, 100, 12'h321, 1'b0);
        check("sat_reach", 32'(plot_count), 32'h1FFFF);
        plot_one(201, 101, 12'h322, 1'b0);
        check("sat_hold", 32'(plot_count), 32'h1FFFF);
        plot_one(202, 102, 12'h323, 1'b1);
        check("clear_on_plot", 32'(plot_count), 32'd0);
        plot_one(203, 103, 12'h324, 1'b0);
        check("count_after_clear", 32'(plot_count), 32'd1);
        wait_drain("sat");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
